// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive engine: frame FSM states,
// frame geometry constants and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Mouse packets always carry a 1 in bit 3 of their first byte.
  localparam int SYNC_BIT = 3;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_packet_rx_if.sv
// Result bus of the PS/2 packet receiver. The receiver drives it (master),
// the packet consumer samples it (slave).
interface ps2_packet_rx_if #(
  parameter int PKT_BYTES = 3
);
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   packet_valid;
  logic [8*PKT_BYTES-1:0] packet;
  logic                   parity_err;
  logic                   frame_err;
  logic                   timeout_err;
  logic                   busy;

  modport master (
    output byte_valid, byte_data, packet_valid, packet,
           parity_err, frame_err, timeout_err, busy
  );

  modport slave (
    input byte_valid, byte_data, packet_valid, packet,
          parity_err, frame_err, timeout_err, busy
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchroniser, then a stability filter
// that only follows the line after FILTER_LEN identical samples, then a
// falling-edge detect on the filtered result. Raw-to-filtered latency is
// 2 + FILTER_LEN cycles.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic line_in,
  output logic line_filt,
  output logic line_fall
);

  localparam int CW = $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] stab_cnt;

  // Synchroniser; idles high like an undriven PS/2 line.
  always_ff @(posedge qzt_clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], line_in};
  end

  // Stability filter: the count restarts whenever the sample agrees with the
  // filtered level, so only an unbroken run of FILTER_LEN new samples flips it.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      line_filt <= 1'b1;
      line_fall <= 1'b0;
      stab_cnt  <= '0;
    end else begin
      line_fall <= 1'b0;
      if (sync_q[1] == line_filt) begin
        stab_cnt <= '0;
      end else if (stab_cnt == CNT_LAST) begin
        line_filt <= sync_q[1];
        line_fall <= line_filt;
        stab_cnt  <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receive engine: decodes 11-bit frames from the
// filtered lines and assembles good bytes into PKT_BYTES-byte mouse packets,
// with parity, framing and inactivity-timeout checking.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (S with data = 0)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | next S carries the parity bit
//   STOP   | next S carries the stop bit; frame is evaluated
module ps2_packet_rx
  import ps2_pkg::*;
#(
  parameter int PKT_BYTES   = 3,
  parameter int TIMEOUT_CYC = 50_000,
  parameter int FILTER_LEN  = 8,
  parameter int CHECK_SYNC  = 1
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic enable,
  input  logic ps2c_in,
  input  logic ps2d_in,
  ps2_packet_rx_if.master rx_bus
);

  localparam int PW = 8 * PKT_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC);
  localparam logic [1:0]    IDX_LAST = 2'(PKT_BYTES - 1);

  logic ps2c_filt_unused;
  logic data_fall_unused;
  logic ps2d_filt;
  logic samp;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_q;
  logic [1:0]    idx;
  logic [PW-1:0] pbuf;
  logic [PW-1:0] pkt_next;
  logic [TW-1:0] tmr;
  logic          tmr_clear;
  logic          timeout_hit;

  logic          byte_valid_q;
  logic [7:0]    byte_data_q;
  logic          packet_valid_q;
  logic [PW-1:0] packet_q;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          timeout_err_q;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .line_in   (ps2c_in),
    .line_filt (ps2c_filt_unused),
    .line_fall (samp)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .line_in   (ps2d_in),
    .line_filt (ps2d_filt),
    .line_fall (data_fall_unused)
  );

  // The timer only runs while there is something to lose: a frame in flight
  // or a partially assembled packet. It reloads on every sample event.
  assign tmr_clear   = samp || (state == IDLE && idx == 2'd0);
  assign timeout_hit = !tmr_clear && (tmr == TW'(1));

  // Partial packet with the byte currently in the shift register slotted in.
  always_comb begin
    pkt_next = pbuf;
    pkt_next[8*idx +: 8] = shreg;
  end

  // Frame FSM, packet assembly, timeout and all result registers.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_q          <= 1'b0;
      idx            <= '0;
      pbuf           <= '0;
      tmr            <= TMR_LOAD;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      packet_valid_q <= 1'b0;
      packet_q       <= '0;
      parity_err_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      byte_valid_q   <= 1'b0;
      packet_valid_q <= 1'b0;
      parity_err_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      timeout_err_q  <= 1'b0;

      if (!enable) begin
        state   <= IDLE;
        bit_cnt <= '0;
        idx     <= '0;
        tmr     <= TMR_LOAD;
      end else begin
        if (tmr_clear)       tmr <= TMR_LOAD;
        else if (tmr != '0)  tmr <= tmr - 1'b1;

        if (samp) begin
          unique case (state)
            IDLE: begin
              if (!ps2d_filt) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shreg   <= {ps2d_filt, shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              par_q <= ps2d_filt;
              state <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (!ps2d_filt) begin
                frame_err_q <= 1'b1;
                idx         <= '0;
              end else if (!odd_parity_ok(shreg, par_q)) begin
                parity_err_q <= 1'b1;
                idx          <= '0;
              end else begin
                byte_valid_q <= 1'b1;
                byte_data_q  <= shreg;
                if (idx == 2'd0 && CHECK_SYNC != 0 && !shreg[SYNC_BIT]) begin
                  idx <= '0;
                end else if (idx == IDX_LAST) begin
                  packet_q       <= pkt_next;
                  packet_valid_q <= 1'b1;
                  idx            <= '0;
                end else begin
                  pbuf <= pkt_next;
                  idx  <= idx + 1'b1;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end else if (timeout_hit) begin
          state         <= IDLE;
          idx           <= '0;
          timeout_err_q <= 1'b1;
        end
      end
    end
  end

  assign rx_bus.byte_valid   = byte_valid_q;
  assign rx_bus.byte_data    = byte_data_q;
  assign rx_bus.packet_valid = packet_valid_q;
  assign rx_bus.packet       = packet_q;
  assign rx_bus.parity_err   = parity_err_q;
  assign rx_bus.frame_err    = frame_err_q;
  assign rx_bus.timeout_err  = timeout_err_q;
  assign rx_bus.busy         = (state != IDLE) || (idx != 2'd0);

endmodule
